// File: rtl/ofdm_frame_sequencer_if.sv
// rtl/ofdm_frame_sequencer_if.sv - sample-in / symbol-out bundle for the OFDM frame sequencer
interface ofdm_frame_sequencer_if #(
    parameter int INPUT_WIDTH       = 12,
    parameter int NFFT              = 2048,
    parameter int SYMBOLS_PER_FRAME = 14
);
    localparam int SYM_W = ($clog2(SYMBOLS_PER_FRAME) < 1) ? 1 : $clog2(SYMBOLS_PER_FRAME);
    localparam int IDX_W = $clog2(NFFT);

    logic                          in_valid;
    logic                          frame_start;
    logic signed [INPUT_WIDTH-1:0] in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q;

    logic                          out_valid;
    logic                          out_sos;
    logic                          out_eos;
    logic signed [INPUT_WIDTH-1:0] out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q;
    logic [SYM_W-1:0]              out_symbol_idx;
    logic [IDX_W-1:0]              out_sample_idx;

    modport slave (
        input  in_valid, frame_start, in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q,
        output out_valid, out_sos, out_eos, out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q,
               out_symbol_idx, out_sample_idx
    );

    modport master (
        output in_valid, frame_start, in_ch0_i, in_ch0_q, in_ch1_i, in_ch1_q,
        input  out_valid, out_sos, out_eos, out_ch0_i, out_ch0_q, out_ch1_i, out_ch1_q,
               out_symbol_idx, out_sample_idx
    );
endinterface

// File: rtl/ofdm_frame_sequencer.sv
// rtl/ofdm_frame_sequencer.sv - strips preamble and cyclic prefixes, forwards indexed data-symbol bodies
module ofdm_frame_sequencer #(
    parameter int INPUT_WIDTH       = 12,
    parameter int NFFT              = 2048,
    parameter int CP_LEN            = 512,
    parameter int SYMBOLS_PER_FRAME = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   abort,
    ofdm_frame_sequencer_if.slave  smp,
    output logic                   busy,
    output logic                   frame_done,
    output logic [7:0]             dropped_count
);
    localparam int SYM_W = ($clog2(SYMBOLS_PER_FRAME) < 1) ? 1 : $clog2(SYMBOLS_PER_FRAME);
    localparam int IDX_W = $clog2(NFFT);
    localparam int CNT_W = $clog2((NFFT > CP_LEN) ? NFFT : CP_LEN);

    localparam logic [CNT_W-1:0] NFFT_LAST = CNT_W'(NFFT - 1);
    localparam logic [CNT_W-1:0] CP_LAST   = CNT_W'(CP_LEN - 1);
    localparam logic [SYM_W-1:0] SYM_LAST  = SYM_W'(SYMBOLS_PER_FRAME - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, CP, DATA} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [SYM_W-1:0] sym, sym_n;
    logic             fwd, sos_d, eos_d, done_d, drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sym   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sym   <= sym_n;
        end
    end

    // The accepting sample is preamble sample 0, so the preamble count resumes at 1.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sym_n   = sym;
        if (abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            sym_n   = '0;
        end else if (smp.in_valid) begin
            case (state)
                IDLE: begin
                    if (smp.frame_start && enable) begin
                        state_n = PREAMBLE;
                        cnt_n   = CNT_W'(1);
                    end
                end
                PREAMBLE: begin
                    if (cnt == NFFT_LAST) begin
                        state_n = CP;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                CP: begin
                    if (cnt == CP_LAST) begin
                        state_n = DATA;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == NFFT_LAST) begin
                        cnt_n = '0;
                        if (sym == SYM_LAST) begin
                            state_n = IDLE;
                            sym_n   = '0;
                        end else begin
                            state_n = CP;
                            sym_n   = sym + SYM_W'(1);
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        fwd    = smp.in_valid && !abort && (state == DATA);
        sos_d  = fwd && (cnt == '0);
        eos_d  = fwd && (cnt == NFFT_LAST);
        done_d = eos_d && (sym == SYM_LAST);
        drop   = smp.in_valid && smp.frame_start && !abort && (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            smp.out_valid      <= 1'b0;
            smp.out_sos        <= 1'b0;
            smp.out_eos        <= 1'b0;
            frame_done         <= 1'b0;
            smp.out_ch0_i      <= '0;
            smp.out_ch0_q      <= '0;
            smp.out_ch1_i      <= '0;
            smp.out_ch1_q      <= '0;
            smp.out_symbol_idx <= '0;
            smp.out_sample_idx <= '0;
            dropped_count      <= '0;
        end else begin
            smp.out_valid <= fwd;
            smp.out_sos   <= sos_d;
            smp.out_eos   <= eos_d;
            frame_done    <= done_d;
            if (fwd) begin
                smp.out_ch0_i      <= smp.in_ch0_i;
                smp.out_ch0_q      <= smp.in_ch0_q;
                smp.out_ch1_i      <= smp.in_ch1_i;
                smp.out_ch1_q      <= smp.in_ch1_q;
                smp.out_symbol_idx <= sym;
                smp.out_sample_idx <= IDX_W'(cnt);
            end
            if (drop && (dropped_count != 8'hFF)) begin
                dropped_count <= dropped_count + 8'd1;
            end
        end
    end

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_ofdm_frame_sequencer.sv
// tb/tb_ofdm_frame_sequencer.sv - self-checking bench for ofdm_frame_sequencer (NFFT=8, CP_LEN=2, 3 symbols)
module tb_ofdm_frame_sequencer;
    localparam int W    = 12;
    localparam int NFFT = 8;
    localparam int CP   = 2;
    localparam int SPF  = 3;
    localparam int PER  = NFFT + CP;
    localparam int FLEN = NFFT + SPF * PER;

    logic       clk = 1'b0;
    logic       rst, enable, abort;
    logic       busy, frame_done;
    logic [7:0] dropped_count;

    ofdm_frame_sequencer_if #(.INPUT_WIDTH(W), .NFFT(NFFT), .SYMBOLS_PER_FRAME(SPF)) bus ();

    ofdm_frame_sequencer #(
        .INPUT_WIDTH(W), .NFFT(NFFT), .CP_LEN(CP), .SYMBOLS_PER_FRAME(SPF)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .abort(abort), .smp(bus),
        .busy(busy), .frame_done(frame_done), .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] c0i, c0q, c1i, c1q;
        logic [1:0]   sym;
        logic [2:0]   idx;
        logic         sos, eos, done;
    } out_t;

    typedef struct {
        bit v, fs, en, ab, r;
        bit busy;
        int drop;
    } vec_t;

    out_t sb[$];
    out_t last;
    int   n_vec = 0, n_err = 0;
    bit   m_active = 0;
    int   m_pos = 0, m_drop = 0;
    int   tcur, obs_valid, obs_done, done_t, sos_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0d: got %0h expected %0h", name, tcur, act, exp);
        end
    endtask

    // Reference model works from the position of each sample within the frame.
    task automatic step(input bit v, input bit fs, input bit en, input bit ab, input bit r);
        out_t         e;
        bit           fwd;
        int           q, s;
        logic [W-1:0] d0, d1, d2, d3;
        d0 = W'($urandom); d1 = W'($urandom); d2 = W'($urandom); d3 = W'($urandom);
        bus.in_valid = v; bus.frame_start = fs; enable = en; abort = ab; rst = r;
        bus.in_ch0_i = d0; bus.in_ch0_q = d1; bus.in_ch1_i = d2; bus.in_ch1_q = d3;
        fwd = 1'b0;
        e   = '0;
        if (r) begin
            m_active = 0; m_pos = 0; m_drop = 0; last = '0;
        end else if (ab) begin
            m_active = 0; m_pos = 0;
        end else if (v) begin
            if (m_active) begin
                if (fs && m_drop < 255) m_drop++;
                if (m_pos >= NFFT && ((m_pos - NFFT) % PER) >= CP) begin
                    q = ((m_pos - NFFT) % PER) - CP;
                    s = (m_pos - NFFT) / PER;
                    fwd = 1'b1;
                    e.c0i = d0; e.c0q = d1; e.c1i = d2; e.c1q = d3;
                    e.sym  = 2'(s);
                    e.idx  = 3'(q);
                    e.sos  = (q == 0);
                    e.eos  = (q == NFFT - 1);
                    e.done = (q == NFFT - 1) && (s == SPF - 1);
                    sb.push_back(e);
                    last = e;
                end
                if (m_pos == FLEN - 1) m_active = 0;
                else m_pos++;
            end else if (fs && en) begin
                m_active = 1;
                m_pos    = 1;
            end
        end
        @(posedge clk);
        #1;
        if (frame_done) begin
            obs_done++;
            done_t = tcur;
        end
        if (r) begin
            check("reset_outputs", 64'({bus.out_valid, bus.out_sos, bus.out_eos, frame_done, busy,
                                        dropped_count, bus.out_symbol_idx, bus.out_sample_idx}), 64'd0);
            check("reset_ch", 64'({bus.out_ch0_i, bus.out_ch0_q, bus.out_ch1_i, bus.out_ch1_q}), 64'd0);
            sb.delete();
        end else begin
            check("out_valid", 64'(bus.out_valid), 64'(fwd));
            if (bus.out_valid) begin
                obs_valid++;
                if (bus.out_sos) sos_t = tcur;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sample", 64'({bus.out_ch0_i, bus.out_ch0_q, bus.out_ch1_i, bus.out_ch1_q,
                                         bus.out_symbol_idx, bus.out_sample_idx,
                                         bus.out_sos, bus.out_eos, frame_done}), 64'(e));
                end
            end else begin
                check("idle_hold", 64'({bus.out_sos, bus.out_eos, frame_done, bus.out_ch0_i,
                                        bus.out_ch0_q, bus.out_ch1_i, bus.out_ch1_q}),
                      64'({3'b000, last.c0i, last.c0q, last.c1i, last.c1q}));
            end
        end
        check("busy", 64'(busy), 64'(m_active));
        check("dropped_count", 64'(dropped_count), 64'(m_drop));
        tcur++;
    endtask

    task automatic begin_test();
        step(0, 0, 1, 0, 1);
        tcur = 0; obs_valid = 0; obs_done = 0; done_t = -1; sos_t = -1;
    endtask

    initial begin
        vec_t tbl[10];
        bus.in_valid = 0; bus.frame_start = 0;
        bus.in_ch0_i = '0; bus.in_ch0_q = '0; bus.in_ch1_i = '0; bus.in_ch1_q = '0;
        rst = 1; enable = 0; abort = 0;
        last = '0; tcur = 0; obs_valid = 0; obs_done = 0; done_t = -1; sos_t = -1;

        // {v, fs, en, ab, r, busy, dropped}
        tbl[0] = '{0, 0, 0, 0, 1, 0, 0};
        tbl[1] = '{0, 1, 1, 0, 0, 0, 0};
        tbl[2] = '{1, 1, 0, 0, 0, 0, 0};
        tbl[3] = '{1, 1, 1, 1, 0, 0, 0};
        tbl[4] = '{1, 1, 1, 0, 0, 1, 0};
        tbl[5] = '{1, 1, 1, 0, 0, 1, 1};
        tbl[6] = '{0, 1, 1, 0, 0, 1, 1};
        tbl[7] = '{1, 0, 1, 1, 0, 0, 1};
        tbl[8] = '{1, 1, 1, 1, 0, 0, 1};
        tbl[9] = '{0, 0, 1, 0, 1, 0, 0};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].v, tbl[i].fs, tbl[i].en, tbl[i].ab, tbl[i].r);
            check("tbl_busy", 64'(busy), 64'(tbl[i].busy));
            check("tbl_dropped", 64'(dropped_count), 64'(tbl[i].drop));
        end

        // Continuous frame
        begin_test();
        step(1, 1, 1, 0, 0);
        repeat (39) step(1, 0, 1, 0, 0);
        check("a_valid_count", 64'(obs_valid), 64'd24);
        check("a_done_count", 64'(obs_done), 64'd1);
        check("a_done_at", 64'(done_t), 64'd37);
        check("a_last_sos", 64'(sos_t), 64'd30);

        // Gapped input
        begin_test();
        step(1, 1, 1, 0, 0);
        for (int i = 0; i < 90; i++) step(i[0], 0, 1, 0, 0);
        check("b_valid_count", 64'(obs_valid), 64'd24);
        check("b_done_count", 64'(obs_done), 64'd1);

        // Drop while busy, back-to-back restart
        begin_test();
        for (int t = 0; t < 80; t++) begin
            step(1, (t == 0) || (t == 15) || (t == 38), 1, 0, 0);
            if (t == 49) check("c_first_sos_frame2", 64'(sos_t), 64'd48);
        end
        check("c_dropped", 64'(dropped_count), 64'd1);
        check("c_done_count", 64'(obs_done), 64'd2);
        check("c_done_at", 64'(done_t), 64'd75);

        // Abort mid-frame, then restart
        begin_test();
        for (int t = 0; t < 65; t++) begin
            step(1, (t == 0) || (t == 25), 1, t == 22, 0);
            if (t == 24) begin
                check("d_done_before_restart", 64'(obs_done), 64'd0);
                check("d_valid_before_restart", 64'(obs_valid), 64'd10);
            end
        end
        check("d_done_count", 64'(obs_done), 64'd1);
        check("d_done_at", 64'(done_t), 64'd62);

        // Enable low ignored; enable dropped mid-frame
        begin_test();
        step(1, 1, 0, 0, 0);
        check("e_ignored_busy", 64'(busy), 64'd0);
        for (int t = 1; t < 42; t++) step(1, t == 1, t < 5, 0, 0);
        check("e_done_count", 64'(obs_done), 64'd1);
        check("e_done_at", 64'(done_t), 64'd38);
        check("e_dropped", 64'(dropped_count), 64'd0);

        // Reset mid-frame, then saturate the drop counter
        begin_test();
        for (int t = 0; t < 25; t++) step(1, t == 0, 1, 0, t == 24);
        repeat (340) step(1, 1, 1, 0, 0);
        check("f_dropped_sat", 64'(dropped_count), 64'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
